// File: rtl/fish_scanner.sv
// -----------------------------------------------------------------------------
// fish_scanner
//   Horizontal fish-motion generator. After a Load the fish left edge (Fpos)
//   sweeps right/left between X_MIN and X_MAX-width, one STEP every Peff clocks
//   while Run is high. Hit reports, one edge late, whether the rod x-position
//   lies over the fish.
//
// Parameters
//   X_MIN    left bound of the fish left edge (signed pixels)
//   X_MAX    right bound of the fish right edge (signed pixels)
//   STEP     pixels moved per step, 1..15
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   Load       in   pulse: capture Start_pos/Fish_w/Period, enter LOADED
//   Clear      in   pulse: unload fish, enter IDLE (Fpos/Dir hold)
//   Run        in   level: motion advances only while high
//   Start_pos  in   [10:0] signed start x of fish left edge
//   Fish_w     in   [5:0]  fish width, 1..63
//   Period     in   [15:0] clocks per step, 0 behaves as 1
//   Rpos       in   [10:0] signed rod x-position
//   Fpos       out  [10:0] signed fish left edge
//   Dir        out  1 = moving right, 0 = moving left
//   Step       out  one-cycle pulse after each motion step
//   Hit        out  registered Rpos within [Fpos, Fpos+width]
//   Loaded     out  high in LOADED or SCAN
// -----------------------------------------------------------------------------
module fish_scanner #(
    parameter int X_MIN = -64,
    parameter int X_MAX = 639,
    parameter int STEP  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Load,
    input  logic               Clear,
    input  logic               Run,
    input  logic signed [10:0] Start_pos,
    input  logic        [5:0]  Fish_w,
    input  logic        [15:0] Period,
    input  logic signed [10:0] Rpos,
    output logic signed [10:0] Fpos,
    output logic               Dir,
    output logic               Step,
    output logic               Hit,
    output logic               Loaded
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADED,
        S_SCAN
    } state_t;

    localparam logic signed [11:0] C_XMIN = 12'(X_MIN);
    localparam logic signed [11:0] C_XMAX = 12'(X_MAX);
    localparam logic signed [11:0] C_STEP = 12'(STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [10:0] r_fpos;
    logic               r_dir;
    logic               r_step;
    logic               r_hit;
    logic        [15:0] r_timer;
    logic        [5:0]  r_width;
    logic        [15:0] r_period;

    logic               w_loaded;
    logic               w_scan_run;
    logic               w_step_en;
    logic        [15:0] w_pm1;

    // All position arithmetic is done 12-bit signed so intermediate sums
    // near the bounds cannot wrap.
    logic signed [11:0] w_fpos12;
    logic signed [11:0] w_w12;
    logic signed [11:0] w_rpos12;
    logic signed [11:0] w_right_sum;
    logic signed [11:0] w_right_lim;
    logic signed [11:0] w_left_diff;
    logic signed [11:0] w_hit_hi;
    logic signed [11:0] w_mv_fpos;
    logic               w_mv_dir;
    logic signed [11:0] w_start12;
    logic signed [11:0] w_ld_w12;
    logic signed [11:0] w_ld_hi;
    logic signed [11:0] w_ld_fpos;
    logic               w_hit_nxt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (Clear) begin
            w_state_nxt = S_IDLE;
        end else if (Load) begin
            w_state_nxt = S_LOADED;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_IDLE;
                S_LOADED: if (Run) w_state_nxt = S_SCAN;
                S_SCAN:   if (!Run) w_state_nxt = S_LOADED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / enables ----------------
    always_comb begin
        w_loaded   = (r_state != S_IDLE);
        // Clear and Load outrank motion, so a step edge that coincides with
        // either produces no movement and no Step pulse.
        w_scan_run = (r_state == S_SCAN) && Run && !Clear && !Load;
        w_step_en  = w_scan_run && (r_timer == w_pm1);
    end

    // ---------------- datapath arithmetic ----------------
    assign w_pm1       = (r_period == '0) ? '0 : (r_period - 16'd1);
    assign w_fpos12    = {r_fpos[10], r_fpos};
    assign w_w12       = {6'b000000, r_width};
    assign w_rpos12    = {Rpos[10], Rpos};
    assign w_right_sum = w_fpos12 + C_STEP + w_w12;
    assign w_right_lim = C_XMAX - w_w12;
    assign w_left_diff = w_fpos12 - C_STEP;
    assign w_hit_hi    = w_fpos12 + w_w12;
    assign w_hit_nxt   = w_loaded && (w_rpos12 >= w_fpos12) && (w_rpos12 <= w_hit_hi);

    assign w_start12   = {Start_pos[10], Start_pos};
    assign w_ld_w12    = {6'b000000, Fish_w};
    assign w_ld_hi     = C_XMAX - w_ld_w12;

    always_comb begin
        w_ld_fpos = w_start12;
        if (w_start12 < C_XMIN) begin
            w_ld_fpos = C_XMIN;
        end else if (w_start12 > w_ld_hi) begin
            w_ld_fpos = w_ld_hi;
        end
    end

    // A bounce step clamps to the bound and reverses; it still counts as a
    // step even when the clamped position equals the current one.
    always_comb begin
        w_mv_fpos = w_fpos12;
        w_mv_dir  = r_dir;
        if (r_dir) begin
            if (w_right_sum > C_XMAX) begin
                w_mv_fpos = w_right_lim;
                w_mv_dir  = 1'b0;
            end else begin
                w_mv_fpos = w_fpos12 + C_STEP;
            end
        end else begin
            if (w_left_diff < C_XMIN) begin
                w_mv_fpos = C_XMIN;
                w_mv_dir  = 1'b1;
            end else begin
                w_mv_fpos = w_left_diff;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fpos   <= 11'(C_XMIN);
            r_dir    <= 1'b1;
            r_step   <= 1'b0;
            r_hit    <= 1'b0;
            r_timer  <= '0;
            r_width  <= '0;
            r_period <= '0;
        end else begin
            r_step <= 1'b0;
            r_hit  <= w_hit_nxt;
            if (Clear) begin
                r_timer <= '0;
            end else if (Load) begin
                r_timer  <= '0;
                r_dir    <= 1'b1;
                r_width  <= Fish_w;
                r_period <= Period;
                r_fpos   <= 11'(w_ld_fpos);
            end else if (w_scan_run) begin
                if (w_step_en) begin
                    r_timer <= '0;
                    r_step  <= 1'b1;
                    r_fpos  <= 11'(w_mv_fpos);
                    r_dir   <= w_mv_dir;
                end else begin
                    r_timer <= r_timer + 16'd1;
                end
            end
        end
    end

    assign Fpos   = r_fpos;
    assign Dir    = r_dir;
    assign Step   = r_step;
    assign Hit    = r_hit;
    assign Loaded = w_loaded;

endmodule

// File: tb/tb_fish_scanner.sv
module tb_fish_scanner;

    logic               Clk;
    logic               Reset;
    logic               Load;
    logic               Clear;
    logic               Run;
    logic signed [10:0] Start_pos;
    logic        [5:0]  Fish_w;
    logic        [15:0] Period;
    logic signed [10:0] Rpos;
    logic signed [10:0] Fpos;
    logic               Dir;
    logic               Step;
    logic               Hit;
    logic               Loaded;

    int total;
    int bad;

    fish_scanner #(
        .X_MIN(-64),
        .X_MAX(639),
        .STEP (2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Load),
        .Clear    (Clear),
        .Run      (Run),
        .Start_pos(Start_pos),
        .Fish_w   (Fish_w),
        .Period   (Period),
        .Rpos     (Rpos),
        .Fpos     (Fpos),
        .Dir      (Dir),
        .Step     (Step),
        .Hit      (Hit),
        .Loaded   (Loaded)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic load;
        logic clear;
        logic run;
        int   start;
        int   w;
        int   period;
        int   rpos;
        int   e_fpos;
        logic e_dir;
        logic e_step;
        logic e_hit;
        logic e_loaded;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int fp, input logic d,
                             input logic s, input logic h, input logic l);
        check({tag, ".fpos"},   int'(Fpos),   fp);
        check({tag, ".dir"},    int'(Dir),    int'(d));
        check({tag, ".step"},   int'(Step),   int'(s));
        check({tag, ".hit"},    int'(Hit),    int'(h));
        check({tag, ".loaded"}, int'(Loaded), int'(l));
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic void add(input logic ld, input logic cl, input logic rn,
                                input int st, input int w, input int p, input int rp,
                                input int fp, input logic d, input logic s,
                                input logic h, input logic l);
        vec_t v;
        v.load = ld; v.clear = cl; v.run = rn;
        v.start = st; v.w = w; v.period = p; v.rpos = rp;
        v.e_fpos = fp; v.e_dir = d; v.e_step = s; v.e_hit = h; v.e_loaded = l;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic ld, input logic cl, input logic rn,
                         input int st, input int w, input int p, input int rp);
        Load      = ld;
        Clear     = cl;
        Run       = rn;
        Start_pos = 11'(st);
        Fish_w    = 6'(w);
        Period    = 16'(p);
        Rpos      = 11'(rp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        // ---- reset state ----
        #12;
        check_all("reset", -64, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        check_all("idle", -64, 1'b1, 1'b0, 1'b0, 1'b0);

        // ---- basic sweep: -20, w=20, Period=4 ----
        add(1,0,1, -20,20,4, -100,  -20,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -20,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -20,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -20,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -20,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -18,1,1,0,1);
        add(0,0,1, -20,20,4, -100,  -18,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -18,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -18,1,0,0,1);
        add(0,0,1, -20,20,4, -100,  -16,1,1,0,1);
        add(0,0,1, -20,20,4, -100,  -16,1,0,0,1);
        // ---- right bounce: 610, w=20, Period=1 ----
        add(1,0,1, 610,20,1, -100,  610,1,0,0,1);
        add(0,0,1, 610,20,1, -100,  610,1,0,0,1);
        add(0,0,1, 610,20,1, -100,  612,1,1,0,1);
        add(0,0,1, 610,20,1, -100,  614,1,1,0,1);
        add(0,0,1, 610,20,1, -100,  616,1,1,0,1);
        add(0,0,1, 610,20,1, -100,  618,1,1,0,1);
        add(0,0,1, 610,20,1, -100,  619,0,1,0,1);
        add(0,0,1, 610,20,1, -100,  617,0,1,0,1);
        // ---- hit window: Fpos=100, w=20, Run low ----
        add(1,0,0, 100,20,4, 100,   100,1,0,0,1);
        add(0,0,0, 100,20,4, 100,   100,1,0,1,1);
        add(0,0,0, 100,20,4, 120,   100,1,0,1,1);
        add(0,0,0, 100,20,4, 99,    100,1,0,0,1);
        add(0,0,0, 100,20,4, 121,   100,1,0,0,1);
        add(0,0,0, 100,20,4, 110,   100,1,0,1,1);
        add(0,1,0, 100,20,4, 0,     100,1,0,0,0);
        add(0,0,0, 100,20,4, 110,   100,1,0,0,0);
        // Load and Clear together: Clear wins, Start_pos ignored.
        add(1,1,0, 200,20,4, 110,   100,1,0,0,0);
        add(0,0,0, 200,20,4, 110,   100,1,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].load, tbl[i].clear, tbl[i].run, tbl[i].start,
                  tbl[i].w, tbl[i].period, tbl[i].rpos);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].e_fpos, tbl[i].e_dir,
                      tbl[i].e_step, tbl[i].e_hit, tbl[i].e_loaded);
        end

        // ---- pause: Period=10, Run dropped after 6 counted edges ----
        drive(1'b1, 1'b0, 1'b1, 0, 10, 10, -200);
        tick();
        check("pause.load_fpos", int'(Fpos), 0);
        Load = 1'b0;
        for (int i = 0; i < 7; i++) begin   // 1 entry edge + 6 counted edges
            tick();
            check($sformatf("pause.pre%0d.step", i), int'(Step), 0);
        end
        Run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("pause.hold%0d.step", i), int'(Step), 0);
        end
        check("pause.hold.fpos", int'(Fpos), 0);
        Run = 1'b1;
        for (int i = 0; i < 4; i++) begin   // re-entry edge + timer 7,8,9
            tick();
            check($sformatf("pause.resume%0d.step", i), int'(Step), 0);
        end
        tick();
        check("pause.step", int'(Step), 1);
        check("pause.fpos", int'(Fpos), 2);

        // ---- left clamp on load, then left bounce ----
        drive(1'b1, 1'b0, 1'b1, -100, 20, 1, -200);
        tick();
        check("lclamp.fpos", int'(Fpos), -64);
        check("lclamp.dir", int'(Dir), 1);
        drive(1'b1, 1'b0, 1'b1, 619, 20, 1, -200);
        tick();
        check("rstart.fpos", int'(Fpos), 619);
        Load = 1'b0;
        tick();                              // enter SCAN
        tick();                              // clamp step at right bound
        check("rclamp.fpos", int'(Fpos), 619);
        check("rclamp.dir", int'(Dir), 0);
        check("rclamp.step", int'(Step), 1);
        for (int i = 0; i < 341; i++) tick();
        check("lbounce.pre.fpos", int'(Fpos), -63);
        check("lbounce.pre.dir", int'(Dir), 0);
        tick();
        check("lbounce.fpos", int'(Fpos), -64);
        check("lbounce.dir", int'(Dir), 1);
        check("lbounce.step", int'(Step), 1);
        tick();
        check("lbounce.after.fpos", int'(Fpos), -62);

        // ---- asynchronous reset mid-SCAN ----
        drive(1'b1, 1'b0, 1'b1, -20, 20, 1, -10);
        tick();
        Load = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check_all("prerst", -14, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check_all("asyncrst", -64, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("rsthold", -64, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fish_scanner.md
# fish_scanner

Horizontal fish-motion generator for the fishing-game VGA design; sits directly upstream of the game-state controller and supplies the moving fish position that the controller compares against the rod. Once loaded with a start position, width and step period, the block sweeps the fish left and right between screen bounds while the player holds a direction button. It also reports, registered, whether the rod x-position currently lies over the fish.

## Interface
- X_MIN, default -64: left bound of fish left edge (signed pixels).
- X_MAX, default 639: right bound of fish right edge (signed pixels).
- STEP, default 2: pixels moved per step, 1..15.
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  one-cycle pulse; captures Start_pos, Fish_w, Period.
- Clear  in  1  one-cycle pulse; unloads fish, returns to IDLE.
- Run  in  1  level; motion advances only while high (driven by left||right).
- Start_pos  in  11  signed start x of fish left edge.
- Fish_w  in  6  fish width in pixels, 1..63.
- Period  in  16  clock cycles per step; 0 treated as 1.
- Rpos  in  11  signed rod x-position.
- Fpos  out  11  signed current fish left edge.
- Dir  out  1  1 = moving right, 0 = moving left.
- Step  out  1  one-cycle pulse on the cycle Fpos changes due to motion.
- Hit  out  1  registered: Rpos within [Fpos, Fpos+width].
- Loaded  out  1  high in LOADED or SCAN.

## Operation
- States: IDLE, LOADED, SCAN. Reset → IDLE.
- IDLE: Load → LOADED. Otherwise hold.
- LOADED: Run=1 → SCAN; timer not cleared on this transition.
- SCAN: Run=0 → LOADED with timer held.
- Any state: Load → LOADED; timer cleared; Dir ← 1; width/period registers captured; Fpos ← Start_pos clamped to [X_MIN, X_MAX − Fish_w].
- Any state: Clear → IDLE; timer cleared. Fpos and Dir hold.
- Priority: Reset > Clear > Load > motion.
- Timer, 16-bit: in SCAN with Run=1, if timer == Peff−1, step and timer ← 0; else timer ← timer+1. Peff = max(Period_reg, 1).
- Step moving right: if Fpos+STEP+w > X_MAX, Fpos ← X_MAX−w and Dir ← 0; else Fpos ← Fpos+STEP.
- Step moving left: if Fpos−STEP < X_MIN, Fpos ← X_MIN and Dir ← 1; else Fpos ← Fpos−STEP.
- A clamp step still pulses Step even if Fpos is unchanged.
- All position arithmetic is signed 12-bit to avoid overflow; results fit 11 bits by clamping.
- Hit ← (state != IDLE) && Rpos ≥ Fpos && Rpos ≤ Fpos+w. Uses the pre-edge Fpos register and the current Rpos.

## Timing
- Reset values: Fpos = X_MIN, Dir = 1, Step = 0, Hit = 0, Loaded = 0, timer = 0, width/period registers = 0.
- Load sampled at edge N: Fpos valid and Loaded = 1 after N.
- With Run held high, state is SCAN after edge N+1; first step at edge N+1+Peff; subsequent steps every Peff edges.
- Step is high for exactly the cycle following the updating edge.
- Hit lags Fpos/Rpos by one edge.
- Load on a step edge: Load wins; no Step pulse.
- Run dropping on a step edge: step does not occur; timer holds its value.
- Reset mid-SCAN: all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset: assert Reset mid-SCAN → immediately Fpos = -64, Dir = 1, Step = 0, Hit = 0, Loaded = 0.
- Basic sweep: Load Start_pos = -20, Fish_w = 20, Period = 4, Run = 1 from edge N → Fpos = -20 after N, -18 after N+5, -16 after N+9; Step high only in those cycles.
- Right bounce: Load Start_pos = 610, w = 20, Period = 1, Run = 1 → Fpos 612, 614, 616, 618, 619 (Dir → 0), then 617.
- Left bounce and clamp: Load Start_pos = -100 → Fpos = -64; set Dir = 0 by sweeping, then step → Fpos pinned at -64, Dir → 1.
- Pause: Period = 10, drop Run after 6 counted cycles for 20 cycles → no Step; resume → Step after 4 more edges.
- Hit: Fpos = 100, w = 20; Rpos = 100 and 120 → Hit = 1 one edge later; Rpos = 99 and 121 → 0. Clear → Hit = 0 next edge. Load+Clear same cycle → IDLE.
